// File: rtl/axi_lite_chain_pkg.sv
// Shared types and constants for the AXI4-Lite master/passthrough/slave loopback chain.
package axi_lite_chain_pkg;

  localparam logic [1:0]  RespOkay    = 2'b00;
  localparam logic [1:0]  RespSlvErr  = 2'b10;
  localparam logic [31:0] PatternBase = 32'hA5A5_0000;
  localparam logic [31:0] ErrReadData = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWresp,
    StRaddr,
    StRdata,
    StDone
  } mst_state_e;

  // Data word the master writes to (and expects back from) transaction idx
  function automatic logic [31:0] pattern_word(input logic [7:0] idx);
    return PatternBase | {24'h0, idx};
  endfunction

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi_lite_mem_slv.sv
// Memory-backed AXI4-Lite slave: one outstanding write and one outstanding read.
// Optional macro SLV_BACKPRESSURE_EN: READYs follow a free-running toggle and a one-cycle
// gap is inserted after each B/R handshake before the next request is accepted.
module axi_lite_mem_slv
  import axi_lite_chain_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  output logic [1:0]          b_resp_o,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic [1:0]          r_resp_o
);

  localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic                aw_got_q, w_got_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic                b_valid_q, r_valid_q;
  logic [1:0]          b_resp_q, r_resp_q;
  logic [DATA_W-1:0]   r_data_q;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (32'(a[ADDR_W-1:2]) < MEM_DEPTH);
  endfunction

`ifdef SLV_BACKPRESSURE_EN
  logic tog_q, b_gap_q, r_gap_q;

  // Toggle for alternating READY, plus one-cycle gap after each response handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tog_q   <= 1'b0;
      b_gap_q <= 1'b0;
      r_gap_q <= 1'b0;
    end else begin
      tog_q   <= ~tog_q;
      b_gap_q <= b_valid_q & b_ready_i;
      r_gap_q <= r_valid_q & r_ready_i;
    end
  end

  assign aw_ready_o = tog_q & ~aw_got_q & ~b_valid_q & ~b_gap_q;
  assign w_ready_o  = tog_q & ~w_got_q & ~b_valid_q & ~b_gap_q;
  assign ar_ready_o = tog_q & ~r_valid_q & ~r_gap_q;
`else
  assign aw_ready_o = 1'b1;
  assign w_ready_o  = 1'b1;
  assign ar_ready_o = 1'b1;
`endif

  logic                aw_hs, w_hs, ar_hs, wr_fire, wr_ok, rd_ok;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;

  assign aw_hs   = aw_valid_i & aw_ready_o;
  assign w_hs    = w_valid_i & w_ready_o;
  assign ar_hs   = ar_valid_i & ar_ready_o;
  // Commit as soon as both halves are held or arriving, so BVALID rises the next cycle
  assign wr_fire = (aw_got_q | aw_hs) & (w_got_q | w_hs) & ~b_valid_q;
  assign wr_addr = aw_got_q ? aw_addr_q : aw_addr_i;
  assign wr_data = w_got_q ? w_data_q : w_data_i;
  assign wr_strb = w_got_q ? w_strb_q : w_strb_i;
  assign wr_ok   = addr_ok(wr_addr);
  assign rd_ok   = addr_ok(ar_addr_i);

  // Memory array: contents are not reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_fire && wr_ok) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wr_strb[b]) mem_q[wr_addr[MemAw+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write/read channel control and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
      r_valid_q <= 1'b0;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
    end else begin
      if (wr_fire) begin
        aw_got_q  <= 1'b0;
        w_got_q   <= 1'b0;
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_ok ? RespOkay : RespSlvErr;
      end else begin
        if (aw_hs) begin
          aw_got_q  <= 1'b1;
          aw_addr_q <= aw_addr_i;
        end
        if (w_hs) begin
          w_got_q  <= 1'b1;
          w_data_q <= w_data_i;
          w_strb_q <= w_strb_i;
        end
        if (b_valid_q && b_ready_i) b_valid_q <= 1'b0;
      end
      if (ar_hs && !r_valid_q) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_ok ? mem_q[ar_addr_i[MemAw+1:2]] : ErrReadData;
        r_resp_q  <= rd_ok ? RespOkay : RespSlvErr;
      end else if (r_valid_q && r_ready_i) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  assign b_valid_o = b_valid_q;
  assign b_resp_o  = b_resp_q;
  assign r_valid_o = r_valid_q;
  assign r_data_o  = r_data_q;
  assign r_resp_o  = r_resp_q;

endmodule

// File: rtl/axi_lite_mst_pt_slv_chain.sv
// AXI4-Lite loopback: write/readback traffic master, zero-latency passthrough monitor,
// memory slave. Optional macro SLV_BACKPRESSURE_EN throttles the slave READYs.
module axi_lite_mst_pt_slv_chain
  import axi_lite_chain_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_TXN   = 16,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] wr_count,
  output logic [7:0] rd_count
);

  // Internal bus; master and slave share the same nets so the passthrough adds no latency
  logic                aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic                ar_valid, ar_ready, r_valid, r_ready;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [DATA_W-1:0]   w_data, r_data;
  logic [DATA_W/8-1:0] w_strb;
  logic [1:0]          b_resp, r_resp;

  mst_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d, err_q, err_d, wr_cnt_q, rd_cnt_q;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d, last;

  assign last = (32'(idx_q) + 32'd1) >= NUM_TXN;

  // Master state register
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      err_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Master next-state
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        idx_d   = '0;
        state_d = StWaddr;
      end
      StWaddr: begin
        if (aw_valid && aw_ready) aw_done_d = 1'b1;
        if (w_valid && w_ready) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWresp;
        end
      end
      StWresp: begin
        if (b_valid) begin
          if (b_resp != RespOkay) err_d = sat_inc8(err_q);
          if (last) begin
            idx_d   = '0;
            state_d = StRaddr;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StWaddr;
          end
        end
      end
      StRaddr: begin
        if (ar_ready) state_d = StRdata;
      end
      StRdata: begin
        if (r_valid) begin
          if (r_data != pattern_word(idx_q) || r_resp != RespOkay) err_d = sat_inc8(err_q);
          if (last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StRaddr;
          end
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Master outputs: bus drive and status
  always_comb begin
    aw_valid  = (state_q == StWaddr) && !aw_done_q;
    w_valid   = (state_q == StWaddr) && !w_done_q;
    aw_addr   = ADDR_W'({idx_q, 2'b00});
    w_data    = pattern_word(idx_q);
    w_strb    = '1;
    b_ready   = (state_q == StWresp);
    ar_valid  = (state_q == StRaddr);
    ar_addr   = ADDR_W'({idx_q, 2'b00});
    r_ready   = (state_q == StRdata);
    done      = (state_q == StDone);
    pass      = (state_q == StDone) && (err_q == 8'd0);
    err_count = err_q;
  end

  // Passthrough monitor: counts completed B and R handshakes
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (b_valid && b_ready) wr_cnt_q <= sat_inc8(wr_cnt_q);
      if (r_valid && r_ready) rd_cnt_q <= sat_inc8(rd_cnt_q);
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;

  axi_lite_mem_slv #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_slv (
    .clk_i      (aclk),
    .rst_i      (aresetn),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .aw_addr_i  (aw_addr),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .b_resp_o   (b_resp),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .ar_addr_i  (ar_addr),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp)
  );

endmodule

// File: tb/tb_axi_lite_mst_pt_slv_chain.sv
// Bench: default chain with random resets and a transaction-level model checked every cycle,
// a NUM_TXN=1 chain, and an out-of-range chain (MEM_DEPTH=8, NUM_TXN=10) that must see SLVERRs.
module tb_axi_lite_mst_pt_slv_chain;
  import axi_lite_chain_pkg::*;

  localparam int unsigned N0 = 16;
  localparam int DefaultLatency = 66;
`ifdef SLV_BACKPRESSURE_EN
  localparam int DoneBound = 400;
`else
  localparam int DoneBound = 200;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_at_edge = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  logic       done0, pass0, done1, pass1, done2, pass2;
  logic [7:0] err0, wr0, rd0, err1, wr1, rd1, err2, wr2, rd2;

  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge <= rst_a;

  axi_lite_mst_pt_slv_chain #(.ADDR_W(8), .DATA_W(32), .NUM_TXN(16), .MEM_DEPTH(16)) dut0 (
    .aclk(clk), .aresetn(rst_a), .done(done0), .pass(pass0),
    .err_count(err0), .wr_count(wr0), .rd_count(rd0)
  );
  axi_lite_mst_pt_slv_chain #(.ADDR_W(8), .DATA_W(32), .NUM_TXN(1), .MEM_DEPTH(16)) dut1 (
    .aclk(clk), .aresetn(rst_b), .done(done1), .pass(pass1),
    .err_count(err1), .wr_count(wr1), .rd_count(rd1)
  );
  axi_lite_mst_pt_slv_chain #(.ADDR_W(8), .DATA_W(32), .NUM_TXN(10), .MEM_DEPTH(8)) dut2 (
    .aclk(clk), .aresetn(rst_b), .done(done2), .pass(pass2),
    .err_count(err2), .wr_count(wr2), .rd_count(rd2)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model of dut0: handshake counts since reset define every expectation
  int         m_aw = 0, m_w = 0, m_b = 0, m_ar = 0, m_r = 0;
  logic       st_aw = 1'b0, st_w = 1'b0, st_ar = 1'b0;
  logic [7:0] p_aw_addr = '0, p_ar_addr = '0;
  logic [31:0] p_w_data = '0;
  logic [3:0] p_w_strb = '0;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      check("reset_outputs", {done0, pass0, err0, wr0, rd0}, '0);
      check("reset_valids", {dut0.aw_valid, dut0.w_valid, dut0.ar_valid, dut0.b_valid,
                             dut0.r_valid}, '0);
      m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
      st_aw = 1'b0; st_w = 1'b0; st_ar = 1'b0;
    end else begin
      check("wr_count", wr0, 8'(m_b));
      check("rd_count", rd0, 8'(m_r));
      check("err_count", err0, 0);
      check("done", done0, m_r == N0);
      check("pass", pass0, m_r == N0);
      if (st_aw) check("aw_hold", {dut0.aw_valid, dut0.aw_addr}, {1'b1, p_aw_addr});
      if (st_w) check("w_hold", {dut0.w_valid, dut0.w_data, dut0.w_strb},
                      {1'b1, p_w_data, p_w_strb});
      if (st_ar) check("ar_hold", {dut0.ar_valid, dut0.ar_addr}, {1'b1, p_ar_addr});
      if (dut0.aw_valid && dut0.aw_ready) begin
        check("aw_addr", dut0.aw_addr, 8'(m_aw * 4));
        m_aw++;
      end
      if (dut0.w_valid && dut0.w_ready) begin
        check("w_data", {dut0.w_data, dut0.w_strb}, {32'hA5A5_0000 | 32'(m_w), 4'hF});
        m_w++;
      end
      if (dut0.b_valid && dut0.b_ready) begin
        check("b_resp", dut0.b_resp, 2'b00);
        m_b++;
      end
      if (dut0.ar_valid && dut0.ar_ready) begin
        check("ar_addr_after_writes", {dut0.ar_addr, 32'(m_b)}, {8'(m_ar * 4), 32'(N0)});
        m_ar++;
      end
      if (dut0.r_valid && dut0.r_ready) begin
        check("r_data", {dut0.r_data, dut0.r_resp}, {32'hA5A5_0000 | 32'(m_r), 2'b00});
        m_r++;
      end
      st_aw = dut0.aw_valid && !dut0.aw_ready;
      st_w  = dut0.w_valid && !dut0.w_ready;
      st_ar = dut0.ar_valid && !dut0.ar_ready;
      p_aw_addr = dut0.aw_addr;
      p_ar_addr = dut0.ar_addr;
      p_w_data  = dut0.w_data;
      p_w_strb  = dut0.w_strb;
    end
  end

  // Single-transaction chain: exactly one write to 0x00 carrying the base pattern
  always @(negedge clk) begin
    if (!rst_b && dut1.aw_valid && dut1.aw_ready) check("dut1_aw_addr", dut1.aw_addr, 8'h00);
    if (!rst_b && dut1.w_valid && dut1.w_ready) check("dut1_w_data", dut1.w_data, 32'hA5A5_0000);
  end

  task automatic wait_done0(output int cyc);
    cyc = 0;
    while (!done0 && cyc < DoneBound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_final0(input string tag, input int cyc);
    check({tag, "_done"}, done0, 1'b1);
    check({tag, "_pass"}, pass0, 1'b1);
    check({tag, "_err"}, err0, 8'd0);
    check({tag, "_wr"}, wr0, 8'd16);
    check({tag, "_rd"}, rd0, 8'd16);
`ifdef SLV_BACKPRESSURE_EN
    check({tag, "_slower"}, cyc > DefaultLatency, 1'b1);
`else
    check({tag, "_latency"}, cyc, DefaultLatency);
`endif
  endtask

  initial begin
    int cyc;
    repeat (5) @(posedge clk);
    #1;
    check("init_reset_dut1", {done1, pass1, err1, wr1, rd1}, '0);
    check("init_reset_dut2", {done2, pass2, err2, wr2, rd2}, '0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_done0(cyc);
    check_final0("first_run", cyc);

    cyc = 0;
    while (!(done1 && done2) && cyc < 2 * DoneBound) begin
      @(negedge clk);
      cyc++;
    end
    check("one_txn_final", {done1, pass1, err1, wr1, rd1}, {1'b1, 1'b1, 8'd0, 8'd1, 8'd1});
    // Words 8 and 9 fall outside an 8-word memory: 2 write SLVERRs + 2 bad readbacks
    check("oob_final", {done2, pass2, err2, wr2, rd2}, {1'b1, 1'b0, 8'd4, 8'd10, 8'd10});

    // Random mid-run resets; the per-cycle model checks everything
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 rst_a = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 rst_a = 1'b0;
      repeat ($urandom_range(5, 80)) @(posedge clk);
    end

    @(posedge clk);
    #1 rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    cyc = 0;
    while (!(dut0.state_q == StRdata && dut0.idx_q == 8'd5) && cyc < DoneBound) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_rdata5", dut0.state_q == StRdata && dut0.idx_q == 8'd5, 1'b1);
    check("wr_before_mid_reset", wr0, 8'd16);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_cleared", {done0, pass0, err0, wr0, rd0}, '0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    wait_done0(cyc);
    check_final0("rerun", cyc);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
